// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run sequencer: preload, core reset hold, run with cycle count/limit
// Optional: CORE_RUN_CTRL_DONE_SYNC_EN adds a 2-flop synchronizer on core_done.
module core_run_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CW      = 16,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_start,
  input  logic [CW-1:0] cycle_limit,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          job_done,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FINISH} state_t;

  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [CW-1:0] CYC_ONE = CW'(1);

  state_t        state, state_nxt;
  logic [CW-1:0] limit_q;
  logic [HW-1:0] hold_cnt;
  logic          done_use;
  logic          limit_hit;
  logic          hold_end;
  logic          beat_acc;

`ifdef CORE_RUN_CTRL_DONE_SYNC_EN
  logic [1:0] done_sync;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_sync <= 2'b00;
    else        done_sync <= {done_sync[0], core_done};
  end
  assign done_use = done_sync[1];
`else
  assign done_use = core_done;
`endif

  // Limit fires in the RUN cycle that would make the count equal the limit.
  assign limit_hit = (limit_q != '0) && ((cycles + CYC_ONE) == limit_q);
  assign hold_end  = (hold_cnt == HW'(RST_CYC - 1));
  assign beat_acc  = (state == LOAD) && ld_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_reset = 1'b1;
    core_req   = 1'b0;
    ld_ready   = 1'b0;
    busy       = 1'b1;
    job_done   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (host_start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_end) state_nxt = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        core_req   = 1'b1;
        if (done_use || limit_hit) state_nxt = FINISH;
      end
      FINISH: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_dat   <= '0;
      hold_cnt  <= '0;
      limit_q   <= '0;
      cycles    <= '0;
      timed_out <= 1'b0;
    end else begin
      mem_wr_en <= beat_acc;
      if (beat_acc) begin
        mem_addr <= ld_addr;
        mem_dat  <= ld_data;
      end
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      if (state == IDLE && host_start) begin
        limit_q   <= cycle_limit;
        cycles    <= '0;
        timed_out <= 1'b0;
      end
      if (state == RUN) begin
        if (cycles != '1) cycles <= cycles + CYC_ONE;
        // A done seen in the same cycle as the limit takes priority.
        if (!done_use && limit_hit) timed_out <= 1'b1;
      end
    end
  end

endmodule
